// File: rtl/wb_stage_unit.sv
// Write-back stage: registers the MEM/WB result onto the register-file write port,
// waiting (with optional timeout) for variable-latency load data.
module wb_stage_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_wb_en,
  input  logic        in_mem_read,
  input  logic [3:0]  in_dest,
  input  logic [31:0] in_alu_result,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        reg_file_wb_en,
  output logic [3:0]  reg_file_wb_address,
  output logic [31:0] reg_file_wb_data,
  output logic        wb_stall,
  output logic        load_pending,
  output logic [3:0]  load_pending_dest,
  output logic        load_timeout,
  output logic        error_flag
);

  typedef enum logic {
    S_IDLE,
    S_WAIT_LOAD
  } state_t;

  localparam bit              LP_TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]         r_dest, w_dest_nxt;
  logic               r_wb_en, w_wb_en_nxt;
  logic [3:0]         r_wb_addr, w_wb_addr_nxt;
  logic [31:0]        r_wb_data, w_wb_data_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_error, w_error_nxt;
  logic               w_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dest    <= '0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_timeout <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dest    <= w_dest_nxt;
      r_wb_en   <= w_wb_en_nxt;
      r_wb_addr <= w_wb_addr_nxt;
      r_wb_data <= w_wb_data_nxt;
      r_timeout <= w_timeout_nxt;
      r_error   <= w_error_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_dest_nxt    = r_dest;
    w_wb_en_nxt   = 1'b0;
    w_wb_addr_nxt = r_wb_addr;
    w_wb_data_nxt = r_wb_data;
    w_timeout_nxt = 1'b0;
    w_error_nxt   = r_error;
    case (r_state)
      S_IDLE: begin
        if (in_valid && in_wb_en) begin
          if (in_mem_read) begin
            w_state_nxt = S_WAIT_LOAD;
            w_dest_nxt  = in_dest;
            w_cnt_nxt   = '0;
          end else begin
            w_wb_en_nxt   = 1'b1;
            w_wb_addr_nxt = in_dest;
            w_wb_data_nxt = in_alu_result;
          end
        end
      end
      S_WAIT_LOAD: begin
        // A response wins over a coincident timeout.
        if (mem_rsp_valid) begin
          w_state_nxt   = S_IDLE;
          w_wb_en_nxt   = 1'b1;
          w_wb_addr_nxt = r_dest;
          w_wb_data_nxt = mem_rsp_data;
        end else if (LP_TO_EN && (r_cnt == LP_LAST)) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
          w_error_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_stall             = (r_state == S_WAIT_LOAD);
  assign wb_stall            = w_stall;
  assign load_pending        = w_stall;
  assign load_pending_dest   = w_stall ? r_dest : '0;
  assign reg_file_wb_en      = r_wb_en;
  assign reg_file_wb_address = r_wb_addr;
  assign reg_file_wb_data    = r_wb_data;
  assign load_timeout        = r_timeout;
  assign error_flag          = r_error;

endmodule

// File: tb/tb_wb_stage_unit.sv
// Directed bench for wb_stage_unit (TIMEOUT_CYCLES=4); outputs sampled 1 time unit after each rising edge.
module tb_wb_stage_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_wb_en = 1'b0;
  logic        in_mem_read = 1'b0;
  logic [3:0]  in_dest = '0;
  logic [31:0] in_alu_result = '0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        reg_file_wb_en;
  logic [3:0]  reg_file_wb_address;
  logic [31:0] reg_file_wb_data;
  logic        wb_stall;
  logic        load_pending;
  logic [3:0]  load_pending_dest;
  logic        load_timeout;
  logic        error_flag;

  int checks = 0;
  int failures = 0;

  wb_stage_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_valid            (in_valid),
    .in_wb_en            (in_wb_en),
    .in_mem_read         (in_mem_read),
    .in_dest             (in_dest),
    .in_alu_result       (in_alu_result),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_data        (mem_rsp_data),
    .reg_file_wb_en      (reg_file_wb_en),
    .reg_file_wb_address (reg_file_wb_address),
    .reg_file_wb_data    (reg_file_wb_data),
    .wb_stall            (wb_stall),
    .load_pending        (load_pending),
    .load_pending_dest   (load_pending_dest),
    .load_timeout        (load_timeout),
    .error_flag          (error_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write port and stall/pending status in one call.
  task automatic chk_wb(input string tag, input logic en, input logic [3:0] addr,
                        input logic [31:0] data, input logic stall, input logic [3:0] pdest);
    chk({tag, ".wb_en"}, 32'(reg_file_wb_en), 32'(en));
    chk({tag, ".addr"},  32'(reg_file_wb_address), 32'(addr));
    chk({tag, ".data"},  reg_file_wb_data, data);
    chk({tag, ".stall"}, 32'(wb_stall), 32'(stall));
    chk({tag, ".pend"},  32'(load_pending), 32'(stall));
    chk({tag, ".pdest"}, 32'(load_pending_dest), 32'(pdest));
  endtask

  task automatic alu(input logic [3:0] d, input logic [31:0] v);
    in_valid = 1'b1; in_wb_en = 1'b1; in_mem_read = 1'b0; in_dest = d; in_alu_result = v;
  endtask

  task automatic ld(input logic [3:0] d);
    in_valid = 1'b1; in_wb_en = 1'b1; in_mem_read = 1'b1; in_dest = d; in_alu_result = 32'h100;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_wb_en = 1'b0; in_mem_read = 1'b0;
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom); in_wb_en = 1'($urandom); in_mem_read = 1'($urandom);
      in_dest = 4'($urandom); in_alu_result = $urandom;
      mem_rsp_valid = 1'($urandom); mem_rsp_data = $urandom;
      tick();
    end
    chk_wb("rst", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    chk("rst.timeout", 32'(load_timeout), 32'd0);
    chk("rst.error", 32'(error_flag), 32'd0);
    idle(); mem_rsp_valid = 1'b0;
    #2 rst = 1'b1;

    // First ALU write, one cycle only, then hold
    alu(4'd3, 32'h12345678); tick();
    chk_wb("alu0", 1'b1, 4'd3, 32'h12345678, 1'b0, 4'd0);
    idle(); tick();
    chk_wb("alu0_hold", 1'b0, 4'd3, 32'h12345678, 1'b0, 4'd0);

    // Back-to-back ALU
    alu(4'd1, 32'hA); tick();
    chk_wb("b2b1", 1'b1, 4'd1, 32'hA, 1'b0, 4'd0);
    alu(4'd2, 32'hB); tick();
    chk_wb("b2b2", 1'b1, 4'd2, 32'hB, 1'b0, 4'd0);
    alu(4'd3, 32'hC); tick();
    chk_wb("b2b3", 1'b1, 4'd3, 32'hC, 1'b0, 4'd0);

    // Non-writing instruction interleaved
    in_valid = 1'b1; in_wb_en = 1'b0; in_mem_read = 1'b0; in_dest = 4'd9; in_alu_result = 32'h99;
    tick();
    chk_wb("nowr", 1'b0, 4'd3, 32'hC, 1'b0, 4'd0);
    alu(4'd15, 32'h44); tick();
    chk_wb("r15", 1'b1, 4'd15, 32'h44, 1'b0, 4'd0);
    in_valid = 1'b1; in_wb_en = 1'b0; in_mem_read = 1'b1; in_dest = 4'd2; tick();
    chk_wb("nowr_str", 1'b0, 4'd15, 32'h44, 1'b0, 4'd0);

    // Response while IDLE is ignored
    idle(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'hFFFF_FFFF; tick();
    chk_wb("rsp_idle", 1'b0, 4'd15, 32'h44, 1'b0, 4'd0);
    mem_rsp_valid = 1'b0;

    // Load with latency 3; frozen ALU R6 behind it
    ld(4'd5); tick();
    chk_wb("ld_c1", 1'b0, 4'd15, 32'h44, 1'b1, 4'd5);
    alu(4'd6, 32'h66); tick();
    chk_wb("ld_c2", 1'b0, 4'd15, 32'h44, 1'b1, 4'd5);
    tick();
    chk_wb("ld_c3", 1'b0, 4'd15, 32'h44, 1'b1, 4'd5);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF; tick();
    chk_wb("ld_c4", 1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0);
    mem_rsp_valid = 1'b0; tick();
    chk_wb("ld_c5", 1'b1, 4'd6, 32'h66, 1'b0, 4'd0);
    chk("ld.error", 32'(error_flag), 32'd0);

    // Timeout after 4 WAIT_LOAD cycles; frozen ALU R8 behind it
    ld(4'd7); tick();
    alu(4'd8, 32'h88);
    for (int i = 0; i < 3; i++) begin
      chk_wb("to_wait", 1'b0, 4'd6, 32'h66, 1'b1, 4'd7);
      chk("to_wait.pulse", 32'(load_timeout), 32'd0);
      tick();
    end
    chk_wb("to_wait4", 1'b0, 4'd6, 32'h66, 1'b1, 4'd7);
    tick();
    chk_wb("to_fire", 1'b0, 4'd6, 32'h66, 1'b0, 4'd0);
    chk("to_fire.pulse", 32'(load_timeout), 32'd1);
    chk("to_fire.error", 32'(error_flag), 32'd1);
    tick();
    chk_wb("to_next", 1'b1, 4'd8, 32'h88, 1'b0, 4'd0);
    chk("to_next.pulse", 32'(load_timeout), 32'd0);
    chk("to_next.error", 32'(error_flag), 32'd1);

    // Response coincides with timeout condition
    ld(4'd9); tick();
    idle(); tick(); tick(); tick();
    chk_wb("co_wait", 1'b0, 4'd8, 32'h88, 1'b1, 4'd9);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D; tick();
    chk_wb("co_wr", 1'b1, 4'd9, 32'hCAFEF00D, 1'b0, 4'd0);
    chk("co.pulse", 32'(load_timeout), 32'd0);
    chk("co.error", 32'(error_flag), 32'd1);
    mem_rsp_valid = 1'b0;

    // Reset asserted mid-WAIT_LOAD
    ld(4'd10); tick();
    idle();
    chk_wb("rw_wait", 1'b0, 4'd9, 32'hCAFEF00D, 1'b1, 4'd10);
    #2 rst = 1'b0; #1;
    chk_wb("rw_async", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    chk("rw_async.error", 32'(error_flag), 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555_AAAA;
    #2 rst = 1'b1;
    tick();
    chk_wb("rw_after", 1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    chk("rw_after.pulse", 32'(load_timeout), 32'd0);
    mem_rsp_valid = 1'b0;
    alu(4'd4, 32'h0BAD_F00D); tick();
    chk_wb("rw_alu", 1'b1, 4'd4, 32'h0BAD_F00D, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
